cla_seq_ctrl: RTL and testbench

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

---
 rtl/cla_seq_pkg.sv | 12 +
 rtl/add4_slice.sv | 24 ++
 rtl/cla_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_cla_seq_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared constants and state encoding for the digit-serial adder controller.
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit adder slice; c3 is the carry into the slice MSB so the
// controller can derive two's-complement overflow on the final slice.
module add4_slice
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c3
);

  logic [SLICE_W:0]   full;
  logic [SLICE_W-1:0] low;

  assign full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign low  = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};

  assign s    = full[SLICE_W-1:0];
  assign cout = full[SLICE_W];
  assign c3   = low[SLICE_W-1];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Digit-serial WIDTH-bit adder: one shared 4-bit slice, LSB slice first.
// Optional subtraction (in_sub port) is enabled with macro CLA_SEQ_SUB_EN.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
`ifdef CLA_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_t state, next_state;

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               carry_reg;
  logic               carry_out_reg;
  logic               overflow_reg;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W+1:0]   base;
  logic               sub_reg;
  logic               init_carry;
  logic               last;

  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               slice_c3;

  // Subtraction is captured with the operands and forces the initial carry.
`ifdef CLA_SEQ_SUB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_reg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_reg <= in_sub;
    end
  end
  assign init_carry = in_sub | in_carry;
`else
  assign sub_reg    = 1'b0;
  assign init_carry = in_carry;
`endif

  // Slice k occupies bits [4k+3:4k]; the shift by two is the slice width.
  assign base  = {cnt, 2'b00};
  assign last  = (cnt == LAST_SLICE);
  assign a_nib = a_reg[base +: SLICE_W];
  assign b_nib = b_reg[base +: SLICE_W] ^ {SLICE_W{sub_reg}};

  add4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // The counter saturates on the last slice; that terminal value ends RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg         <= in_a;
            b_reg         <= in_b;
            carry_reg     <= init_carry;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            cnt           <= '0;
          end
        end
        RUN: begin
          sum_reg[base +: SLICE_W] <= slice_s;
          carry_reg                <= slice_cout;
          if (last) begin
            carry_out_reg <= slice_cout;
            overflow_reg  <= slice_c3 ^ slice_cout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign busy         = (state != IDLE);
  assign out_s        = sum_reg;
  assign out_carry    = carry_out_reg;
  assign out_overflow = overflow_reg;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Scoreboard bench for cla_seq_ctrl (WIDTH=16); subtraction cases run when
// CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_ctrl;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
`ifdef CLA_SEQ_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_carry;
  logic             out_overflow;
  logic             busy;

  int   errors      = 0;
  int   checks      = 0;
  int   accepts     = 0;
  int   exp_accepts = 0;
  exp_t sb[$];

  cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_carry     (in_carry),
`ifdef CLA_SEQ_SUB_EN
    .in_sub       (in_sub),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_s        (out_s),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) accepts <= accepts + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] stalled");
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [WIDTH:0]   full;
    exp_t             r;
    bb   = sub ? ~b : b;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
    r.s  = full[WIDTH-1:0];
    r.c  = full[WIDTH];
    r.v  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic sub, input logic keep);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_carry = cin;
`ifdef CLA_SEQ_SUB_EN
    in_sub   = sub;
`endif
    in_valid = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    exp_accepts++;
    @(posedge clk);
    @(negedge clk);
    in_valid = keep;
  endtask

  task automatic check_output(input int hold);
    int   k = 0;
    exp_t e;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, 4);
    check("sb_size", sb.size(), 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check("sum", out_s, e.s);
    check("carry", out_carry, e.c);
    check("ovf", out_overflow, e.v);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_s, e.s);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_in_ready", in_ready, 1);
    check("post_valid", out_valid, 0);
    check("post_busy", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s"}, out_s, 0);
    check({tag, "_carry"}, out_carry, 0);
    check({tag, "_ovf"}, out_overflow, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_carry  = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    in_sub    = 1'b0;
`endif
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    check("run_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    check_output(0);

    apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check_output(0);
    apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check_output(0);

    // Consumer stalls for five cycles in DONE.
    apply_stimulus(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    check_output(5);

    // Reset in the second RUN cycle abandons the operation.
    apply_stimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrun");
    void'(sb.pop_front());
    apply_stimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
    check_output(0);

    // in_valid held high across two operations with noise on the operands.
    apply_stimulus(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b1);
    in_a = 16'hDEAD;
    in_b = 16'hBEEF;
    check_output(0);
    apply_stimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    check_output(0);
    check("accept_count", accepts, exp_accepts);

`ifdef CLA_SEQ_SUB_EN
    apply_stimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    check_output(0);
    apply_stimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    check_output(0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
